shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/mult_shift_reg.sv | 56 +++++
 rtl/shift_add_multiplier.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter width helper.
package shift_add_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Iteration counter width: ceil(log2(w)), never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/mult_shift_reg.sv
// Combined {accumulator, Q} shift register plus multiplicand for a radix-2 shift-add multiply.
// Load captures the operands; each shift cycle conditionally adds the multiplicand and shifts right by one.
module mult_shift_reg
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               load_i,
   input  logic               shift_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH:0]   sum;
   logic [2*WIDTH:0] shifted;

   // The accumulator keeps a carry bit, so the sum can never overflow.
   always_comb begin
      sum     = acc_q + (q_q[0] ? {1'b0, mcand_q} : '0);
      shifted = {sum, q_q} >> 1;
      next_o  = shifted[2*WIDTH-1:0];
   end

   always_comb begin
      mcand_d = mcand_q;
      acc_d   = acc_q;
      q_d     = q_q;
      if (load_i) begin
         mcand_d = a_i;
         acc_d   = '0;
         q_d     = b_i;
      end else if (shift_i) begin
         acc_d = shifted[2*WIDTH:WIDTH];
         q_d   = shifted[WIDTH-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         mcand_q <= '0;
         acc_q   <= '0;
         q_q     <= '0;
      end else begin
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
      end
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: IDLE/CALC/DONE FSM driving a shift-add datapath.
// One iteration per clock; done pulses WIDTH+1 edges after the accepting edge (counting that edge).
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [2*WIDTH-1:0] shift_next;
   logic               accept;
   logic               calc;
   logic               last_iter;

   always_comb begin
      calc      = (state_q == ST_CALC);
      last_iter = calc && (cnt_q == CNT_LAST);
      // start is only honoured outside CALC, so an operation in flight is never disturbed.
      accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   end

   mult_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift_reg (
      .clock   (clock),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (calc),
      .a_i     (a),
      .b_i     (b),
      .next_o  (shift_next)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_CALC;
         ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q == ST_CALC);
      done    = (state_q == ST_DONE);
      product = product_q;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (calc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Product captures the post-shift value on the final CALC edge and holds until the next one.
   always_comb begin
      product_d = product_q;
      if (last_iter) begin
         product_d = shift_next;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

endmodule
